// File: rtl/reg_wb_pkg.sv
// ----------------------------------------------------------------------------
// reg_wb_pkg: shared types for the register-file writeback arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package reg_wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_port_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2: combinational two-winner round-robin picker, same-address skip. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick2
  import reg_wb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]                 valid_i,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0] addr_i,
  input  logic [PTR_W-1:0]                rr_i,
  output logic [NREQ-1:0]                 grant_o,
  output logic [PTR_W-1:0]                pri_idx_o,
  output logic [PTR_W-1:0]                sec_idx_o,
  output logic                            pri_valid_o,
  output logic                            sec_valid_o
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

  logic [PTR_W:0]   sum_w;
  logic [PTR_W-1:0] idx_w;

  always_comb begin
    grant_o     = '0;
    pri_idx_o   = '0;
    sec_idx_o   = '0;
    pri_valid_o = 1'b0;
    sec_valid_o = 1'b0;
    sum_w       = '0;
    idx_w       = '0;
    for (int i = 0; i < NREQ; i++) begin
      // NREQ need not be a power of two, so wrap explicitly.
      sum_w = {1'b0, rr_i} + (PTR_W+1)'(i);
      if (sum_w >= NREQ_W) sum_w = sum_w - NREQ_W;
      idx_w = sum_w[PTR_W-1:0];
      if (valid_i[idx_w]) begin
        if (!pri_valid_o) begin
          pri_valid_o    = 1'b1;
          pri_idx_o      = idx_w;
          grant_o[idx_w] = 1'b1;
        end else if (!sec_valid_o && (addr_i[idx_w] != addr_i[pri_idx_o])) begin
          sec_valid_o    = 1'b1;
          sec_idx_o      = idx_w;
          grant_o[idx_w] = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter: shares the two register-file write ports, tracks pending writes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid_i,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0] req_addr_i,
  input  logic [NREQ-1:0][N-1:0]          req_data_i,
  output logic [NREQ-1:0]                 req_ready_o,
  input  logic                            alloc_valid_i,
  input  logic [REG_ADDR_W-1:0]           alloc_addr_i,
  output logic                            write_enable1_o,
  output logic [REG_ADDR_W-1:0]           address_write1_o,
  output logic [N-1:0]                    write_data1_o,
  output logic                            write_enable2_o,
  output logic [REG_ADDR_W-1:0]           address_write2_o,
  output logic [N-1:0]                    write_data2_o,
  output logic [NUM_REGS-1:0]             busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_req_t [NREQ-1:0]   req_w;
  logic [NREQ-1:0]      valid_w;
  logic [NREQ-1:0]      grant_w;
  logic [PTR_W-1:0]     pri_idx_w;
  logic [PTR_W-1:0]     sec_idx_w;
  logic [PTR_W-1:0]     last_idx_w;
  logic                 pri_valid_w;
  logic                 sec_valid_w;

  logic [PTR_W-1:0]     rr_q, rr_d;
  wb_port_t             port1_q, port1_d;
  wb_port_t             port2_q, port2_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  for (genvar k = 0; k < NREQ; k++) begin : g_req
    assign req_w[k].addr = req_addr_i[k];
    assign req_w[k].data = req_data_i[k];
  end

  // Masking valid during reset keeps ready low and blocks all state updates.
  assign valid_w = rst_n ? req_valid_i : '0;

  rr_pick2 #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid_i     (valid_w),
    .addr_i      (req_addr_i),
    .rr_i        (rr_q),
    .grant_o     (grant_w),
    .pri_idx_o   (pri_idx_w),
    .sec_idx_o   (sec_idx_w),
    .pri_valid_o (pri_valid_w),
    .sec_valid_o (sec_valid_w)
  );

  assign last_idx_w = sec_valid_w ? sec_idx_w : pri_idx_w;

  always_comb begin
    rr_d    = rr_q;
    port1_d = port1_q;
    port2_d = port2_q;
    busy_d  = busy_q;

    if (pri_valid_w) begin
      rr_d = (last_idx_w == PTR_W'(NREQ-1)) ? '0 : last_idx_w + 1'b1;
    end

    port2_d.we = pri_valid_w;
    if (pri_valid_w) begin
      port2_d.addr = req_w[pri_idx_w].addr;
      port2_d.data = req_w[pri_idx_w].data;
      busy_d[req_w[pri_idx_w].addr] = 1'b0;
    end

    port1_d.we = sec_valid_w;
    if (sec_valid_w) begin
      port1_d.addr = req_w[sec_idx_w].addr;
      port1_d.data = req_w[sec_idx_w].data;
      busy_d[req_w[sec_idx_w].addr] = 1'b0;
    end

    // A fresh reservation outranks a completing write to the same register.
    if (alloc_valid_i) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q    <= '0;
      port1_q <= '0;
      port2_q <= '0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o      = grant_w;
  assign write_enable1_o  = port1_q.we;
  assign address_write1_o = port1_q.addr;
  assign write_data1_o    = port1_q.data;
  assign write_enable2_o  = port2_q.we;
  assign address_write2_o = port2_q.addr;
  assign write_data2_o    = port2_q.data;
  assign busy_o           = busy_q;

endmodule

`default_nettype wire
